pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 105, payload width in bits (full EX/MEM field set).
REQ-002 Parameter CTRL_W, default 4, count of payload MSBs that are control bits (write-enable class), forced to 0 whenever the output is invalid; 1 <= CTRL_W <= DATA_W.
REQ-003 Parameter CNT_W, default 16, stall counter width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous kill of all held entries.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  downstream entry present.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_data  output  DATA_W  downstream payload.
REQ-013 occupancy  output  2  number of held entries, 0..2.
REQ-014 stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-015 Storage: main register plus skid register, each DATA_W bits with a valid bit; occupancy encodes state EMPTY=0, ONE=1, TWO=2.
REQ-016 push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-017 in_ready = (occupancy != 2), derived from registered state only, with no combinational path from out_ready.
REQ-018 out_valid = main valid; out_data = main data, except CTRL_W MSBs forced to 0 when out_valid = 0.
REQ-019 EMPTY: push -> ONE, main <= in_data; no push -> stay.
REQ-020 ONE: push & pop -> ONE, main <= in_data; push & !pop -> TWO, skid <= in_data; !push & pop -> EMPTY; neither -> hold.
REQ-021 TWO: pop -> ONE, main <= skid; !pop -> hold both; push is impossible (in_ready = 0).
REQ-022 Ordering: entries leave in acceptance order; no entry is duplicated or dropped except by flush.
REQ-023 Latency: an entry accepted at edge N appears on out_data in the cycle after edge N when the stage was EMPTY or popped; throughput one entry per cycle with out_ready held high.
REQ-024 Flush has highest priority: at the edge, occupancy <= 0 and both valid bits <= 0; a same-cycle push or pop is discarded or ignored, and data registers need not change.
REQ-025 stall_cnt increments by 1 at each edge where out_valid & !out_ready, saturates at all-ones, and is unaffected by flush.
REQ-026 Payload bits pass unmodified; no arithmetic on in_data.

Reset
REQ-027 While reset is high, asynchronously: main and skid data = 0, both valid bits = 0, occupancy = 0, stall_cnt = 0.
REQ-028 During and after reset: out_valid = 0, out_data = 0, in_ready = 1.
REQ-029 Reset asserted mid-operation (occupancy 1 or 2) discards all entries immediately, without waiting for a clock edge.
REQ-030 First push is accepted at the first rising edge after reset deasserts.

Verification
REQ-031 Streaming: out_ready = 1; push 0x01, 0x02, 0x03 on consecutive edges -> out_data shows 0x01, 0x02, 0x03 on consecutive cycles, occupancy = 1 throughout, stall_cnt = 0.
REQ-032 Skid fill: out_ready = 0; push 0xA then 0xB -> occupancy = 2, in_ready = 0, in_valid with 0xC ignored; raise out_ready -> outputs 0xA then 0xB, in_ready returns to 1 after the first pop.
REQ-033 Flush: occupancy = 2, flush = 1 with in_valid = 1 and data 0xD -> next cycle occupancy = 0, out_valid = 0, control MSBs of out_data = 0, and 0xD is never output.
REQ-034 Stall saturation: CNT_W = 3, out_valid = 1, out_ready = 0 for 10 cycles -> stall_cnt reads 7 and holds there; a flush does not clear it.
REQ-035 Async reset: occupancy = 2, assert reset between edges -> out_valid = 0, occupancy = 0, stall_cnt = 0 before the next edge.
REQ-036 Random: random in_valid/out_ready over 10k cycles against a queue model -> order preserved, occupancy never exceeds 2, no loss without flush.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with a main register and a skid register.
// in_ready comes from registered state only, so out_ready has no combinational path to it.
module pipe_stage_skid #(
   parameter int DATA_W = 105,
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_nx;
   logic [DATA_W-1:0] skid_q;
   logic [DATA_W-1:0] skid_nx;
   logic              main_vld;
   logic              skid_vld;
   logic              push;
   logic              pop;

   assign in_ready  = ~skid_vld;
   assign out_valid = main_vld;
   assign occupancy = state;
   assign push      = in_valid & in_ready;
   assign pop       = main_vld & out_ready;

   // Next occupancy and register contents; flush overrides everything.
   always_comb begin
      state_nx = state;
      main_nx  = main_q;
      skid_nx  = skid_q;
      unique case (state)
         EMPTY: begin
            if (push) begin
               state_nx = ONE;
               main_nx  = in_data;
            end
         end
         ONE: begin
            if (push && pop) begin
               main_nx = in_data;
            end else if (push) begin
               state_nx = TWO;
               skid_nx  = in_data;
            end else if (pop) begin
               state_nx = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               state_nx = ONE;
               main_nx  = skid_q;
            end
         end
         default: state_nx = EMPTY;
      endcase
      if (flush) begin
         state_nx = EMPTY;
      end
   end

   // State, payload and valid registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= EMPTY;
         main_q   <= '0;
         skid_q   <= '0;
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else begin
         state    <= state_nx;
         main_q   <= main_nx;
         skid_q   <= skid_nx;
         main_vld <= (state_nx != EMPTY);
         skid_vld <= (state_nx == TWO);
      end
   end

   // Control MSBs are zeroed whenever nothing valid is presented.
   always_comb begin
      out_data = main_q;
      if (!main_vld) begin
         out_data[DATA_W-1 -: CTRL_W] = '0;
      end
   end

   // Saturating back-pressure counter; flush leaves it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (main_vld && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic
// against a queue model; a narrow second instance checks counter saturation.
module tb_pipe_stage_skid;

   localparam int DW = 105;
   localparam int CW = 4;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;
   logic [NW-1:0] stall_cnt;

   logic       s_flush = 1'b0;
   logic       s_in_valid = 1'b0;
   logic       s_in_ready;
   logic [7:0] s_in_data = '0;
   logic       s_out_valid;
   logic       s_out_ready = 1'b0;
   logic [7:0] s_out_data;
   logic [1:0] s_occ;
   logic [2:0] s_stall;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] q[$];
   int            m_cnt = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   pipe_stage_skid #(.DATA_W(8), .CTRL_W(2), .CNT_W(3)) u_sat (
      .clk(clk), .reset(reset), .flush(s_flush),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .occupancy(s_occ), .stall_cnt(s_stall)
   );

   function automatic logic [DW-1:0] rnd_data();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[DW-1:0];
   endfunction

   // Advance one clock edge and update the queue model from the inputs
   // that were applied during the cycle.
   task automatic step();
      bit            pop;
      bit            push;
      bit            stall;
      bit            fl;
      logic [DW-1:0] d;
      logic [DW-1:0] tmp;
      stall = (q.size() > 0) && !out_ready;
      pop   = (q.size() > 0) && out_ready;
      push  = in_valid && (q.size() < 2);
      fl    = flush;
      d     = in_data;
      @(posedge clk);
      #1;
      if (stall && m_cnt < 65535) m_cnt++;
      if (fl) begin
         q.delete();
      end else begin
         if (pop) tmp = q.pop_front();
         if (push) q.push_back(d);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
         failures++;
         $display("FAIL reset_hold ov=%b ir=%b occ=%0d exp ov=0 ir=1 occ=0",
                  out_valid, in_ready, occupancy);
      end
      checks++;
      if (out_data !== '0 || stall_cnt !== '0) begin
         failures++;
         $display("FAIL reset_data od=%h st=%0d exp 0/0", out_data, stall_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
         failures++;
         $display("FAIL reset_after ov=%b ir=%b od=%h exp 0/1/0",
                  out_valid, in_ready, out_data);
      end
   endtask

   task automatic test_streaming();
      logic [DW-1:0] e;
      out_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         step();
         e = DW'(i);
         checks++;
         if (out_data !== e || occupancy !== 2'd1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stream_%0d od=%h occ=%0d exp od=%h occ=1",
                     i, out_data, occupancy, e);
         end
         checks++;
         if (stall_cnt !== '0) begin
            failures++;
            $display("FAIL stream_stall got=%0d exp=0", stall_cnt);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stream_drain occ=%0d ov=%b exp 0/0", occupancy, out_valid);
      end
   endtask

   task automatic test_skid_fill();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'('hA);
      step();
      in_data   = DW'('hB);
      step();
      checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL skid_full occ=%0d ir=%b exp occ=2 ir=0", occupancy, in_ready);
      end
      in_data = DW'('hC);
      step();
      checks++;
      if (occupancy !== 2'd2 || out_data !== DW'('hA)) begin
         failures++;
         $display("FAIL skid_ignore occ=%0d od=%h exp occ=2 od=a", occupancy, out_data);
      end
      checks++;
      if (stall_cnt !== NW'(m_cnt)) begin
         failures++;
         $display("FAIL skid_stall got=%0d exp=%0d", stall_cnt, m_cnt);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_data !== DW'('hB) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL skid_pop1 od=%h occ=%0d ir=%b exp od=b occ=1 ir=1",
                  out_data, occupancy, in_ready);
      end
      step();
      checks++;
      if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL skid_pop2 occ=%0d ov=%b exp 0/0", occupancy, out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = {4'hF, 101'h1};
      step();
      in_data   = {4'hF, 101'h2};
      step();
      flush     = 1'b1;
      out_ready = 1'b1;
      in_data   = DW'('hD);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data[DW-1 -: CW] !== '0) begin
         failures++;
         $display("FAIL flush occ=%0d ov=%b ctl=%h exp 0/0/0",
                  occupancy, out_valid, out_data[DW-1 -: CW]);
      end
      checks++;
      if (stall_cnt !== NW'(m_cnt)) begin
         failures++;
         $display("FAIL flush_stall got=%0d exp=%0d", stall_cnt, m_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL flush_leak ov=%b od=%h exp ov=0", out_valid, out_data);
         end
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'('h11);
      step();
      in_data   = DW'('h22);
      step();
      in_valid  = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== '0) begin
         failures++;
         $display("FAIL async_reset ov=%b occ=%0d st=%0d exp 0/0/0",
                  out_valid, occupancy, stall_cnt);
      end
      checks++;
      if (in_ready !== 1'b1 || out_data !== '0) begin
         failures++;
         $display("FAIL async_reset_out ir=%b od=%h exp 1/0", in_ready, out_data);
      end
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      m_cnt = 0;
      in_valid  = 1'b1;
      in_data   = DW'('h55);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (occupancy !== 2'd1 || out_data !== DW'('h55)) begin
         failures++;
         $display("FAIL first_push occ=%0d od=%h exp occ=1 od=55", occupancy, out_data);
      end
      step();
   endtask

   task automatic test_stall_sat();
      int e;
      s_in_valid  = 1'b1;
      s_in_data   = 8'hFF;
      s_out_ready = 1'b0;
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      checks++;
      if (s_out_valid !== 1'b1 || s_stall !== 3'd0) begin
         failures++;
         $display("FAIL sat_load ov=%b st=%0d exp 1/0", s_out_valid, s_stall);
      end
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         e = (k > 7) ? 7 : k;
         checks++;
         if (s_stall !== 3'(e)) begin
            failures++;
            $display("FAIL sat_cnt_%0d got=%0d exp=%0d", k, s_stall, e);
         end
      end
      s_flush = 1'b1;
      @(posedge clk);
      #1;
      s_flush = 1'b0;
      checks++;
      if (s_stall !== 3'd7 || s_out_valid !== 1'b0 || s_out_data[7:6] !== 2'b00) begin
         failures++;
         $display("FAIL sat_flush st=%0d ov=%b ctl=%b exp 7/0/00",
                  s_stall, s_out_valid, s_out_data[7:6]);
      end
   endtask

   task automatic test_random();
      int pushed = 0;
      int popped = 0;
      for (int c = 0; c < 10000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 99) == 0);
         in_data   = rnd_data();
         if (in_valid && in_ready && !flush) pushed++;
         if (out_valid && out_ready && !flush) popped++;
         step();
         checks++;
         if (occupancy > 2'd2 || int'(occupancy) != q.size()) begin
            failures++;
            $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", c, occupancy, q.size());
         end
         checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
            failures++;
            $display("FAIL rnd_hs cyc=%0d ov=%b ir=%b size=%0d", c, out_valid, in_ready, q.size());
         end
         checks++;
         if (q.size() > 0) begin
            if (out_data !== q[0]) begin
               failures++;
               $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, out_data, q[0]);
            end
         end else if (out_data[DW-1 -: CW] !== '0) begin
            failures++;
            $display("FAIL rnd_ctl cyc=%0d got=%h exp=0", c, out_data[DW-1 -: CW]);
         end
         checks++;
         if (stall_cnt !== NW'(m_cnt)) begin
            failures++;
            $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", c, stall_cnt, m_cnt);
         end
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (occupancy !== 2'd0 || pushed < popped) begin
         failures++;
         $display("FAIL rnd_drain occ=%0d pushed=%0d popped=%0d", occupancy, pushed, popped);
      end
   endtask

   initial begin
      test_reset();
      @(posedge clk);
      #1;
      test_streaming();
      test_skid_fill();
      test_flush();
      test_async_reset();
      test_stall_sat();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
